// File: rtl/mult_error_accumulator.sv
// Error-distance accumulator for the hybrid multiplier evaluation path: over a run of
// 2^LOG2_SAMPLES exact/approximate product pairs it tracks sum, max, error count and mean ED.
module mult_error_accumulator #(
    parameter int N            = 8,
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*N-1:0]              p_exact,
    input  logic [2*N-1:0]              p_approx,
    output logic                        busy,
    output logic                        done,
    output logic [2*N+LOG2_SAMPLES-1:0] sum_ed,
    output logic [2*N-1:0]              max_ed,
    output logic [LOG2_SAMPLES:0]       err_count,
    output logic [2*N-1:0]              med
);

    localparam int PW = 2 * N;
    localparam int SW = 2 * N + LOG2_SAMPLES;
    localparam int CW = LOG2_SAMPLES + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_SAMPLES) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ed_q;
    logic          ed_vld;

    logic          accept;
    logic [PW-1:0] ed_d;
    logic [SW-1:0] sum_nxt;
    logic [PW-1:0] max_nxt;
    logic [CW-1:0] err_nxt;

    // Magnitude by compare-then-subtract keeps the difference unsigned and symmetric.
    always_comb begin
        accept  = in_valid & in_ready;
        ed_d    = (p_exact >= p_approx) ? (p_exact - p_approx) : (p_approx - p_exact);
        sum_nxt = sum_ed + (ed_vld ? SW'(ed_q) : '0);
        max_nxt = (ed_vld && (ed_q > max_ed)) ? ed_q : max_ed;
        err_nxt = err_count + CW'(ed_vld && (ed_q != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ed_q      <= '0;
            ed_vld    <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_ed    <= '0;
            max_ed    <= '0;
            err_count <= '0;
            med       <= '0;
        end else begin
            ed_vld <= accept;
            if (accept) ed_q <= ed_d;

            // Stage 2 runs every cycle; ed_vld is never set in IDLE/DONE, so the
            // start-time clears below cannot collide with a pending sample.
            sum_ed    <= sum_nxt;
            max_ed    <= max_nxt;
            err_count <= err_nxt;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cnt       <= '0;
                        sum_ed    <= '0;
                        max_ed    <= '0;
                        err_count <= '0;
                        med       <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    med   <= sum_nxt[SW-1:LOG2_SAMPLES];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_error_accumulator.sv
// Randomised and directed bench for mult_error_accumulator with 4-sample runs; expected
// results come from plain-arithmetic ED statistics over the pairs offered in each run.
module tb_mult_error_accumulator;

    localparam int N  = 8;
    localparam int L  = 2;
    localparam int NS = 1 << L;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2*N-1:0]     p_exact = '0;
    logic [2*N-1:0]     p_approx = '0;
    logic               busy;
    logic               done;
    logic [2*N+L-1:0]   sum_ed;
    logic [2*N-1:0]     max_ed;
    logic [L:0]         err_count;
    logic [2*N-1:0]     med;

    int total = 0;
    int bad   = 0;

    logic [2*N-1:0] pe [NS];
    logic [2*N-1:0] pa [NS];
    int             gap [NS];

    mult_error_accumulator #(.N(N), .LOG2_SAMPLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .p_exact(p_exact), .p_approx(p_approx), .busy(busy), .done(done),
        .sum_ed(sum_ed), .max_ed(max_ed), .err_count(err_count), .med(med)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pairs(input int e0, a0, e1, a1, e2, a2, e3, a3, input int g);
        pe[0] = 16'(e0); pa[0] = 16'(a0); pe[1] = 16'(e1); pa[1] = 16'(a1);
        pe[2] = 16'(e2); pa[2] = 16'(a2); pe[3] = 16'(e3); pa[3] = 16'(a3);
        for (int i = 0; i < NS; i++) gap[i] = g;
    endtask

    // Drives one complete run from the current (IDLE or DONE) state and checks it.
    task automatic run_and_check(input string name, input bit mid_start);
        longint es, em, ec, d;
        es = 0; em = 0; ec = 0;
        for (int i = 0; i < NS; i++) begin
            d = (longint'(pe[i]) > longint'(pa[i])) ? longint'(pe[i]) - longint'(pa[i])
                                                    : longint'(pa[i]) - longint'(pe[i]);
            es += d;
            if (d > em) em = d;
            if (d != 0) ec++;
        end

        // A pair offered together with start must be dropped.
        start = 1'b1; in_valid = 1'b1; p_exact = 16'hffff; p_approx = 16'h0000;
        tick();
        start = 1'b0; in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s start_ready: got %0b want 1", name, in_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s start_done: got %0b want 0", name, done); end
        total++; if (sum_ed !== '0 || max_ed !== '0 || err_count !== '0 || med !== '0) begin
            bad++; $display("FAIL %s start_clear: sum=%0d max=%0d err=%0d med=%0d want all 0", name, sum_ed, max_ed, err_count, med);
        end

        for (int i = 0; i < NS; i++) begin
            for (int g = 0; g < gap[i]; g++) tick();
            if (mid_start && i == 2) begin
                start = 1'b1; tick(); start = 1'b0;
                total++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
                    bad++; $display("FAIL %s mid_start: busy=%0b ready=%0b want 1 1", name, busy, in_ready);
                end
            end
            in_valid = 1'b1; p_exact = pe[i]; p_approx = pa[i];
            tick();
            in_valid = 1'b0; p_exact = $urandom(); p_approx = $urandom();
        end

        total++; if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL %s drain: done=%0b busy=%0b ready=%0b want 0 1 0", name, done, busy, in_ready);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL %s done_flags: done=%0b busy=%0b ready=%0b want 1 0 0", name, done, busy, in_ready);
        end
        total++; if (sum_ed !== (2*N+L)'(es)) begin bad++; $display("FAIL %s sum_ed: got %0d want %0d", name, sum_ed, es); end
        total++; if (max_ed !== (2*N)'(em)) begin bad++; $display("FAIL %s max_ed: got %0d want %0d", name, max_ed, em); end
        total++; if (err_count !== (L+1)'(ec)) begin bad++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, ec); end
        total++; if (med !== (2*N)'(es >> L)) begin bad++; $display("FAIL %s med: got %0d want %0d", name, med, es >> L); end

        // Results must hold while idle in DONE, even with in_valid offered.
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        total++; if (done !== 1'b1 || sum_ed !== (2*N+L)'(es) || err_count !== (L+1)'(ec)) begin
            bad++; $display("FAIL %s hold: done=%0b sum=%0d err=%0d want 1 %0d %0d", name, done, sum_ed, err_count, es, ec);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready: got %0b want 0", name, in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy: got %0b want 0", name, busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done: got %0b want 0", name, done); end
        total++; if (sum_ed !== '0) begin bad++; $display("FAIL %s sum_ed: got %0d want 0", name, sum_ed); end
        total++; if (max_ed !== '0) begin bad++; $display("FAIL %s max_ed: got %0d want 0", name, max_ed); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL %s err_count: got %0d want 0", name, err_count); end
        total++; if (med !== '0) begin bad++; $display("FAIL %s med: got %0d want 0", name, med); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_basic();
        set_pairs(100, 100, 200, 196, 50, 58, 0, 0, 0);
        run_and_check("basic", 1'b0);
    endtask

    task automatic test_extreme();
        set_pairs(65025, 0, 65025, 0, 65025, 0, 65025, 0, 0);
        run_and_check("extreme", 1'b0);
    endtask

    task automatic test_gaps();
        set_pairs(100, 100, 200, 196, 50, 58, 0, 0, 3);
        run_and_check("gaps", 1'b0);
    endtask

    task automatic test_restart();
        set_pairs(100, 100, 196, 200, 58, 50, 0, 0, 1);
        run_and_check("mid_start", 1'b1);
        set_pairs(10, 9, 10, 9, 10, 9, 10, 9, 0);
        run_and_check("restart_done", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; p_exact = 16'd300; p_approx = 16'd7;
            tick();
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_all_zero("mid_run_reset");
        tick();
        rst_n = 1'b1;
        tick();
        set_pairs(100, 100, 200, 196, 50, 58, 0, 0, 0);
        run_and_check("after_reset", 1'b0);
    endtask

    task automatic test_random();
        int a, b, m;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NS; i++) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                pe[i] = 16'(a * b);
                m = $urandom_range(0, 3);
                case (m)
                    0: pa[i] = pe[i];
                    1: pa[i] = pe[i] ^ 16'($urandom_range(0, 255));
                    2: pa[i] = 16'($urandom_range(0, 65535));
                    default: pa[i] = 16'(a * b) & 16'hff00;
                endcase
                gap[i] = $urandom_range(0, 2);
            end
            run_and_check($sformatf("random%0d", r), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_gaps();
        test_restart();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
